// File: rtl/packer_pkg.sv
// packer_pkg: shared types and helpers for the UART-byte to RGB444 packer.
//   pack_state_t : position within a 3-byte / 2-pixel group
//   rgb444_t     : {R[3:0],G[3:0],B[3:0]} pixel
//   pixel0/1     : assemble the two pixels of a group from the byte fields
package packer_pkg;

    typedef enum logic [1:0] {
        S_B0,
        S_B1,
        S_B2
    } pack_state_t;

    typedef logic [11:0] rgb444_t;

    // Nibble field positions within a received byte
    localparam int unsigned NIB_HI_MSB = 7;
    localparam int unsigned NIB_HI_LSB = 4;
    localparam int unsigned NIB_LO_MSB = 3;
    localparam int unsigned NIB_LO_LSB = 0;

    // Pixel 0 = {B0[7:4], B0[3:0], B1[7:4]}
    function automatic rgb444_t pixel0(input logic [7:0] b0, input logic [7:0] b1);
        return {b0, b1[NIB_HI_MSB:NIB_HI_LSB]};
    endfunction

    // Pixel 1 = {B1[3:0], B2[7:4], B2[3:0]}
    function automatic rgb444_t pixel1(input logic [7:0] b1, input logic [7:0] b2);
        return {b1[NIB_LO_MSB:NIB_LO_LSB], b2};
    endfunction

endpackage

// File: rtl/idle_timer.sv
// idle_timer: counts enabled cycles and pulses `expired` for one cycle when
// the count reaches LIMIT, then restarts from zero.
//   clk, rst : clock, asynchronous active-high reset
//   en       : count this cycle
//   clr      : synchronous clear (wins over en)
//   expired  : one-cycle pulse while count == LIMIT
module idle_timer #(
    parameter int unsigned LIMIT = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic expired
);

    localparam int unsigned CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign expired = (cnt_q == CW'(LIMIT));

    // Self-restart on expiry keeps `expired` a single-cycle pulse even
    // before the owner's state change has cleared the timer.
    always_comb begin
        cnt_d = cnt_q;
        if (clr || expired) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rgb_packer.sv
// rgb_packer: packs the UART byte stream (3 bytes per 2 pixels) into RGB444
// pixels with sequential frame-buffer addresses.
//   clk, rst   : clock, asynchronous active-high reset
//   rx_data    : received byte, valid when rx_ready
//   rx_ready   : one-cycle byte strobe
//   sof        : one-cycle frame restart strobe
//   pix_data   : registered pixel {R,G,B}
//   pix_addr   : registered frame-buffer address of pix_data
//   pix_valid  : one-cycle pixel strobe
//   frame_done : pulses with the last pixel of a frame
//   drop_err   : pulses when a partial group is discarded on idle timeout
module rgb_packer
    import packer_pkg::*;
#(
    parameter int unsigned IMG_WIDTH   = 1024,
    parameter int unsigned IMG_HEIGHT  = 768,
    parameter int unsigned TIMEOUT_CYC = 100000,
    parameter int unsigned ADDR_W      = $clog2(IMG_WIDTH * IMG_HEIGHT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_ready,
    input  logic              sof,
    output logic [11:0]       pix_data,
    output logic [ADDR_W-1:0] pix_addr,
    output logic              pix_valid,
    output logic              frame_done,
    output logic              drop_err
);

    localparam int unsigned LAST_PIX = IMG_WIDTH * IMG_HEIGHT - 1;

    if (((IMG_WIDTH * IMG_HEIGHT) % 2) != 0) begin : g_odd_frame
        $error("rgb_packer: IMG_WIDTH*IMG_HEIGHT must be even");
    end

    pack_state_t       state_q, state_d;
    logic [7:0]        hold_q, hold_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    rgb444_t           pix_data_q, pix_data_d;
    logic [ADDR_W-1:0] pix_addr_q, pix_addr_d;
    logic              pix_valid_q, pix_valid_d;
    logic              frame_done_q, frame_done_d;
    logic              drop_err_q, drop_err_d;

    logic              tmr_en, tmr_clr, tmr_expired;
    pack_state_t       cur_state;
    logic              emit;

    assign tmr_en  = (state_q != S_B0) && !rx_ready;
    assign tmr_clr = rx_ready || sof || (state_q == S_B0);

    idle_timer #(
        .LIMIT (TIMEOUT_CYC)
    ) u_idle_timer (
        .clk     (clk),
        .rst     (rst),
        .en      (tmr_en),
        .clr     (tmr_clr),
        .expired (tmr_expired)
    );

    // sof and timeout both force the group back to S_B0 before the byte of
    // this cycle is examined, so a coincident byte becomes a fresh B0.
    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        addr_d       = addr_q;
        pix_data_d   = pix_data_q;
        pix_addr_d   = pix_addr_q;
        pix_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        drop_err_d   = 1'b0;
        cur_state    = state_q;
        emit         = 1'b0;

        if (sof) begin
            cur_state = S_B0;
            state_d   = S_B0;
            addr_d    = '0;
        end else if (tmr_expired) begin
            cur_state  = S_B0;
            state_d    = S_B0;
            drop_err_d = 1'b1;
        end

        if (rx_ready) begin
            case (cur_state)
                S_B0: begin
                    hold_d  = rx_data;
                    state_d = S_B1;
                end
                S_B1: begin
                    pix_data_d = pixel0(hold_q, rx_data);
                    hold_d[NIB_LO_MSB:NIB_LO_LSB] = rx_data[NIB_LO_MSB:NIB_LO_LSB];
                    emit    = 1'b1;
                    state_d = S_B2;
                end
                S_B2: begin
                    pix_data_d = pixel1(hold_q, rx_data);
                    emit    = 1'b1;
                    state_d = S_B0;
                end
                default: begin
                    state_d = S_B0;
                end
            endcase
        end

        if (emit) begin
            pix_valid_d = 1'b1;
            pix_addr_d  = addr_q;
            if (addr_q == ADDR_W'(LAST_PIX)) begin
                frame_done_d = 1'b1;
                addr_d       = '0;
            end else begin
                addr_d = addr_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_B0;
            hold_q       <= '0;
            addr_q       <= '0;
            pix_data_q   <= '0;
            pix_addr_q   <= '0;
            pix_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            drop_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            addr_q       <= addr_d;
            pix_data_q   <= pix_data_d;
            pix_addr_q   <= pix_addr_d;
            pix_valid_q  <= pix_valid_d;
            frame_done_q <= frame_done_d;
            drop_err_q   <= drop_err_d;
        end
    end

    assign pix_data   = pix_data_q;
    assign pix_addr   = pix_addr_q;
    assign pix_valid  = pix_valid_q;
    assign frame_done = frame_done_q;
    assign drop_err   = drop_err_q;

endmodule

// File: tb/tb_rgb_packer.sv
module tb_rgb_packer;

    localparam int unsigned W  = 4;
    localparam int unsigned H  = 2;
    localparam int unsigned TO = 20;
    localparam int unsigned AW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    rx_data = '0;
    logic          rx_ready = 1'b0;
    logic          sof = 1'b0;
    logic [11:0]   pix_data;
    logic [AW-1:0] pix_addr;
    logic          pix_valid;
    logic          frame_done;
    logic          drop_err;

    int unsigned tests_run = 0;
    int unsigned tests_failed = 0;

    logic [11:0]   q_data[$];
    logic [AW-1:0] q_addr[$];
    logic          q_fd[$];
    int            q_cyc[$];
    int            drops = 0;
    int            cyc = 0;
    logic [7:0]    tx[$];

    rgb_packer #(
        .IMG_WIDTH   (W),
        .IMG_HEIGHT  (H),
        .TIMEOUT_CYC (TO),
        .ADDR_W      (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .sof        (sof),
        .pix_data   (pix_data),
        .pix_addr   (pix_addr),
        .pix_valid  (pix_valid),
        .frame_done (frame_done),
        .drop_err   (drop_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        if (pix_valid) begin
            q_data.push_back(pix_data);
            q_addr.push_back(pix_addr);
            q_fd.push_back(frame_done);
            q_cyc.push_back(cyc);
        end
        if (drop_err) drops = drops + 1;
    end

    task automatic clear_capture();
        q_data.delete();
        q_addr.delete();
        q_fd.delete();
        q_cyc.delete();
        drops = 0;
    endtask

    // Sends tx[] with `gap` cycles between strobes (0 = back-to-back).
    task automatic send_seq(input int gap);
        foreach (tx[i]) begin
            @(negedge clk);
            rx_data  = tx[i];
            rx_ready = 1'b1;
            if (gap > 0) begin
                @(negedge clk);
                rx_ready = 1'b0;
                repeat (gap - 1) @(negedge clk);
            end
        end
        @(negedge clk);
        rx_ready = 1'b0;
        tx.delete();
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_sof();
        @(negedge clk);
        sof = 1'b1;
        @(negedge clk);
        sof = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        tests_run++;
        if ({pix_data, pix_addr, pix_valid, frame_done, drop_err} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got data=%h addr=%0d v=%b fd=%b de=%b required all 0",
                     pix_data, pix_addr, pix_valid, frame_done, drop_err);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({pix_valid, frame_done, drop_err} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_idle: got v=%b fd=%b de=%b required 000", pix_valid, frame_done, drop_err);
        end
        clear_capture();
    endtask

    task automatic test_basic();
        clear_capture();
        tx.push_back(8'hF0); tx.push_back(8'h0A); tx.push_back(8'h5C);
        send_seq(10);
        tests_run++;
        if (q_data.size() !== 2) begin
            tests_failed++;
            $display("FAIL basic_count: got %0d pixels required 2", q_data.size());
        end else begin
            tests_run++;
            if (q_data[0] !== 12'hF00 || q_addr[0] !== 3'd0) begin
                tests_failed++;
                $display("FAIL basic_pix0: got %h@%0d required f00@0", q_data[0], q_addr[0]);
            end
            tests_run++;
            if (q_data[1] !== 12'hA5C || q_addr[1] !== 3'd1) begin
                tests_failed++;
                $display("FAIL basic_pix1: got %h@%0d required a5c@1", q_data[1], q_addr[1]);
            end
            tests_run++;
            if (q_fd[0] !== 1'b0 || q_fd[1] !== 1'b0 || drops !== 0) begin
                tests_failed++;
                $display("FAIL basic_flags: got fd=%b%b drops=%0d required 00 0", q_fd[0], q_fd[1], drops);
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_capture();
        tx.push_back(8'h12); tx.push_back(8'h34); tx.push_back(8'h56);
        send_seq(0);
        tests_run++;
        if (q_data.size() !== 2) begin
            tests_failed++;
            $display("FAIL b2b_count: got %0d pixels required 2", q_data.size());
        end else begin
            tests_run++;
            if (q_data[0] !== 12'h123 || q_addr[0] !== 3'd2 || q_data[1] !== 12'h456 || q_addr[1] !== 3'd3) begin
                tests_failed++;
                $display("FAIL b2b_data: got %h@%0d %h@%0d required 123@2 456@3",
                         q_data[0], q_addr[0], q_data[1], q_addr[1]);
            end
            tests_run++;
            if (q_cyc[1] - q_cyc[0] !== 1) begin
                tests_failed++;
                $display("FAIL b2b_spacing: got %0d cycles apart required 1", q_cyc[1] - q_cyc[0]);
            end
        end
    endtask

    task automatic test_timeout();
        clear_capture();
        tx.push_back(8'hAB);
        send_seq(0);
        repeat (TO + 10) @(negedge clk);
        tests_run++;
        if (drops !== 1 || q_data.size() !== 0) begin
            tests_failed++;
            $display("FAIL timeout_drop: got drops=%0d pixels=%0d required 1 0", drops, q_data.size());
        end
        clear_capture();
        tx.push_back(8'h11); tx.push_back(8'h22); tx.push_back(8'h33);
        send_seq(2);
        tests_run++;
        if (q_data.size() !== 2) begin
            tests_failed++;
            $display("FAIL timeout_resume_count: got %0d pixels required 2", q_data.size());
        end else begin
            tests_run++;
            if (q_data[0] !== 12'h112 || q_addr[0] !== 3'd4 || q_data[1] !== 12'h233 || q_addr[1] !== 3'd5) begin
                tests_failed++;
                $display("FAIL timeout_resume: got %h@%0d %h@%0d required 112@4 233@5",
                         q_data[0], q_addr[0], q_data[1], q_addr[1]);
            end
        end
    endtask

    task automatic test_frame_wrap();
        pulse_sof();
        clear_capture();
        for (int i = 0; i < 12; i++) tx.push_back(8'(8'h10 + i));
        tx.push_back(8'hC0); tx.push_back(8'hDE); tx.push_back(8'hF1);
        send_seq(0);
        tests_run++;
        if (q_data.size() !== 10) begin
            tests_failed++;
            $display("FAIL frame_count: got %0d pixels required 10", q_data.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                tests_run++;
                if (q_addr[i] !== AW'(i % 8) || q_fd[i] !== (i == 7)) begin
                    tests_failed++;
                    $display("FAIL frame_pix%0d: got addr=%0d fd=%b required addr=%0d fd=%b",
                             i, q_addr[i], q_fd[i], i % 8, (i == 7));
                end
            end
            tests_run++;
            if (q_data[0] !== 12'h101 || q_data[7] !== 12'hA1B || q_data[8] !== 12'hC0D || q_data[9] !== 12'hEF1) begin
                tests_failed++;
                $display("FAIL frame_data: got %h %h %h %h required 101 a1b c0d ef1",
                         q_data[0], q_data[7], q_data[8], q_data[9]);
            end
        end
    endtask

    task automatic test_sof_with_byte();
        pulse_sof();
        clear_capture();
        for (int i = 0; i < 8; i++) tx.push_back(8'(8'h21 + i));
        send_seq(0);
        @(negedge clk);
        sof      = 1'b1;
        rx_ready = 1'b1;
        rx_data  = 8'h77;
        @(negedge clk);
        sof     = 1'b0;
        rx_data = 8'h88;
        @(negedge clk);
        rx_data = 8'h99;
        @(negedge clk);
        rx_ready = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (q_data.size() !== 7) begin
            tests_failed++;
            $display("FAIL sof_count: got %0d pixels required 7", q_data.size());
        end else begin
            tests_run++;
            if (q_data[0] !== 12'h212 || q_addr[0] !== 3'd0 || q_addr[4] !== 3'd4) begin
                tests_failed++;
                $display("FAIL sof_pre: got %h@%0d last@%0d required 212@0 last@4",
                         q_data[0], q_addr[0], q_addr[4]);
            end
            tests_run++;
            if (q_data[5] !== 12'h778 || q_addr[5] !== 3'd0 || q_data[6] !== 12'h899 || q_addr[6] !== 3'd1) begin
                tests_failed++;
                $display("FAIL sof_restart: got %h@%0d %h@%0d required 778@0 899@1",
                         q_data[5], q_addr[5], q_data[6], q_addr[6]);
            end
            tests_run++;
            if ((q_fd[0] | q_fd[1] | q_fd[2] | q_fd[3] | q_fd[4] | q_fd[5] | q_fd[6]) !== 1'b0) begin
                tests_failed++;
                $display("FAIL sof_no_frame_done: got frame_done seen required none");
            end
        end
    endtask

    task automatic test_reset_mid_group();
        clear_capture();
        @(negedge clk);
        rx_data  = 8'h5A;
        rx_ready = 1'b1;
        @(negedge clk);
        rx_data = 8'h3C;
        @(negedge clk);
        rx_ready = 1'b0;
        tests_run++;
        if (pix_valid !== 1'b1 || pix_data !== 12'h5A3) begin
            tests_failed++;
            $display("FAIL rst_pre: got v=%b data=%h required 1 5a3", pix_valid, pix_data);
        end
        rst = 1'b1;
        #1;
        tests_run++;
        if ({pix_data, pix_addr, pix_valid, frame_done, drop_err} !== '0) begin
            tests_failed++;
            $display("FAIL rst_mid_outputs: got data=%h addr=%0d v=%b required all 0",
                     pix_data, pix_addr, pix_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        clear_capture();
        tx.push_back(8'hAB); tx.push_back(8'hCD); tx.push_back(8'hEF);
        send_seq(1);
        tests_run++;
        if (q_data.size() !== 2) begin
            tests_failed++;
            $display("FAIL rst_after_count: got %0d pixels required 2", q_data.size());
        end else begin
            tests_run++;
            if (q_data[0] !== 12'hABC || q_addr[0] !== 3'd0 || q_data[1] !== 12'hDEF || q_addr[1] !== 3'd1) begin
                tests_failed++;
                $display("FAIL rst_after: got %h@%0d %h@%0d required abc@0 def@1",
                         q_data[0], q_addr[0], q_data[1], q_addr[1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_timeout();
        test_frame_wrap();
        test_sof_with_byte();
        test_reset_mid_group();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
